// File: rtl/vu_pattern_mem.sv
// ============================================================================
// Module      : vu_pattern_mem
// Description : Multi-mode LED colour pattern store with a frame streamer that
//               blanks LEDs above the requested VU level.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module vu_pattern_mem #(
    parameter  int N_LEDS  = 20,
    parameter  int WIDTH   = 24,
    parameter  int N_MODES = 4,
    localparam int DEPTH   = N_MODES * N_LEDS,
    localparam int AW      = $clog2(DEPTH),
    localparam int MW      = (N_MODES > 1) ? $clog2(N_MODES) : 1,
    localparam int LW      = $clog2(N_LEDS + 1),
    localparam int IW      = $clog2(N_LEDS)
) (
    input  logic             i_clk,
    input  logic             i_rst_n,
    input  logic             i_wen,
    input  logic [AW-1:0]    i_waddr,
    input  logic [WIDTH-1:0] i_wdata,
    input  logic             i_start,
    input  logic [MW-1:0]    i_mode,
    input  logic [LW-1:0]    i_level,
    input  logic             i_ready,
    output logic [WIDTH-1:0] o_data,
    output logic             o_valid,
    output logic             o_last,
    output logic             o_busy
);

    localparam logic [WIDTH-1:0] c_RED      = WIDTH'(24'h000F00);
    localparam logic [IW-1:0]    c_LAST_IDX = IW'(N_LEDS - 1);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_READ = 2'd1,
        S_SEND = 2'd2
    } state_t;

    state_t           r_state;
    logic [MW-1:0]    r_mode;
    logic [LW-1:0]    r_level;
    logic [IW-1:0]    r_index;
    logic [AW-1:0]    w_raddr;

    // Power-up contents only; reset deliberately leaves the patterns alone.
    logic [WIDTH-1:0] r_mem [DEPTH] = '{default: c_RED};

    assign w_raddr = AW'(32'(r_mode) * N_LEDS + 32'(r_index));
    assign o_busy  = (r_state != S_IDLE);

    always_ff @(posedge i_clk) begin
        if (i_wen && (32'(i_waddr) < DEPTH)) begin
            r_mem[i_waddr] <= i_wdata;
        end
    end

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_state <= S_IDLE;
            r_mode  <= '0;
            r_level <= '0;
            r_index <= '0;
            o_data  <= '0;
            o_valid <= 1'b0;
            o_last  <= 1'b0;
        end else begin
            case (r_state)
                S_IDLE: begin
                    if (i_start) begin
                        r_mode  <= (32'(i_mode) < N_MODES) ? i_mode : '0;
                        r_level <= (32'(i_level) > N_LEDS) ? LW'(N_LEDS) : i_level;
                        r_index <= '0;
                        r_state <= S_READ;
                    end
                end
                S_READ: begin
                    // Non-blocking read sees the pre-write word on an address collision.
                    o_data  <= (32'(r_index) < 32'(r_level)) ? r_mem[w_raddr] : '0;
                    o_valid <= 1'b1;
                    o_last  <= (r_index == c_LAST_IDX);
                    r_state <= S_SEND;
                end
                S_SEND: begin
                    if (i_ready) begin
                        o_valid <= 1'b0;
                        o_last  <= 1'b0;
                        if (r_index == c_LAST_IDX) begin
                            r_state <= S_IDLE;
                        end else begin
                            r_index <= r_index + 1'b1;
                            r_state <= S_READ;
                        end
                    end
                end
                default: r_state <= S_IDLE;
            endcase
        end
    end

endmodule

`default_nettype wire

// File: tb/tb_vu_pattern_mem.sv
// ============================================================================
// Module      : tb_vu_pattern_mem
// Description : Directed self-checking bench for vu_pattern_mem (3 modes, 20 LEDs).
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_vu_pattern_mem;

    localparam int N_LEDS  = 20;
    localparam int WIDTH   = 24;
    localparam int N_MODES = 3;
    localparam int AW      = 6;
    localparam int MW      = 2;
    localparam int LW      = 5;

    localparam logic [23:0] c_RED = 24'h000F00;

    logic             i_clk;
    logic             i_rst_n;
    logic             i_wen;
    logic [AW-1:0]    i_waddr;
    logic [WIDTH-1:0] i_wdata;
    logic             i_start;
    logic [MW-1:0]    i_mode;
    logic [LW-1:0]    i_level;
    logic             i_ready;
    logic [WIDTH-1:0] o_data;
    logic             o_valid;
    logic             o_last;
    logic             o_busy;

    int n_tests = 0;
    int n_fail  = 0;

    logic [23:0] exp_w [N_LEDS];

    vu_pattern_mem #(
        .N_LEDS (N_LEDS),
        .WIDTH  (WIDTH),
        .N_MODES(N_MODES)
    ) u_dut (
        .i_clk  (i_clk),
        .i_rst_n(i_rst_n),
        .i_wen  (i_wen),
        .i_waddr(i_waddr),
        .i_wdata(i_wdata),
        .i_start(i_start),
        .i_mode (i_mode),
        .i_level(i_level),
        .i_ready(i_ready),
        .o_data (o_data),
        .o_valid(o_valid),
        .o_last (o_last),
        .o_busy (o_busy)
    );

    initial i_clk = 1'b0;
    always #5 i_clk = ~i_clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge i_clk);
        #1;
    endtask

    task automatic wr(input int addr, input logic [23:0] data);
        i_wen   = 1'b1;
        i_waddr = AW'(addr);
        i_wdata = data;
        tick();
        i_wen   = 1'b0;
    endtask

    task automatic start(input int mode, input int level);
        i_mode  = MW'(mode);
        i_level = LW'(level);
        i_start = 1'b1;
        tick();
        i_start = 1'b0;
    endtask

    task automatic fill(input logic [23:0] val);
        for (int k = 0; k < N_LEDS; k++) exp_w[k] = val;
    endtask

    // Consumes a whole frame with i_ready held high, comparing every word.
    task automatic collect(input string tag);
        int cnt;
        for (int k = 0; k < N_LEDS; k++) begin
            cnt = 0;
            while (!o_valid && cnt < 10) begin
                tick();
                cnt++;
            end
            if (!o_valid) begin
                check($sformatf("%s timeout w%0d", tag, k), 32'(o_valid), 32'd1);
                return;
            end
            check($sformatf("%s data w%0d", tag, k), 32'(o_data), 32'(exp_w[k]));
            check($sformatf("%s last w%0d", tag, k), 32'(o_last), 32'(k == N_LEDS - 1));
            tick();
        end
        check({tag, " busy after"},  32'(o_busy),  32'd0);
        check({tag, " valid after"}, 32'(o_valid), 32'd0);
    endtask

    initial begin
        int n;
        i_rst_n = 1'b0;
        i_wen   = 1'b0;
        i_waddr = '0;
        i_wdata = '0;
        i_start = 1'b0;
        i_mode  = '0;
        i_level = '0;
        i_ready = 1'b1;
        tick();
        tick();
        check("rst valid", 32'(o_valid), 32'd0);
        check("rst last",  32'(o_last),  32'd0);
        check("rst busy",  32'(o_busy),  32'd0);
        check("rst data",  32'(o_data),  32'd0);
        i_rst_n = 1'b1;

        // Default contents, full level, plus first-word latency.
        start(0, 20);
        check("lat busy",    32'(o_busy),  32'd1);
        check("lat valid0",  32'(o_valid), 32'd0);
        tick();
        check("lat valid1",  32'(o_valid), 32'd1);
        fill(c_RED);
        collect("full");

        fill(24'h0);
        for (int k = 0; k < 5; k++) exp_w[k] = c_RED;
        start(0, 5);
        collect("lvl5");

        wr(2 * N_LEDS + 3, 24'h0F0000);
        fill(c_RED);
        exp_w[3] = 24'h0F0000;
        start(2, 20);
        collect("mode2");

        wr(0, 24'h0000FF);
        fill(c_RED);
        exp_w[0] = 24'h0000FF;
        start(3, 20);
        collect("mode3clamp");

        fill(c_RED);
        exp_w[3] = 24'h0F0000;
        start(2, 25);
        collect("lvl25");

        fill(24'h0);
        start(1, 0);
        collect("lvl0");

        // Downstream stall on word 0 with a spurious start in the middle.
        fill(c_RED);
        exp_w[3] = 24'h0F0000;
        i_ready = 1'b0;
        start(2, 20);
        tick();
        n = 0;
        for (int c = 0; c < 10; c++) begin
            if (!o_valid || o_data !== c_RED || o_last) n++;
            if (c == 5) begin
                i_mode  = 2'd0;
                i_level = 5'd0;
                i_start = 1'b1;
            end else begin
                i_start = 1'b0;
            end
            tick();
        end
        i_start = 1'b0;
        check("stall held cycles bad", 32'(n), 32'd0);
        i_ready = 1'b1;
        collect("stall");

        // Write to the address being read in the same cycle: old word returns.
        start(2, 20);
        i_wen   = 1'b1;
        i_waddr = AW'(2 * N_LEDS);
        i_wdata = 24'h0000AA;
        tick();
        i_wen   = 1'b0;
        check("rdw valid", 32'(o_valid), 32'd1);
        check("rdw old",   32'(o_data),  32'(c_RED));
        collect("rdw");

        // Out-of-range write must not disturb anything.
        wr(63, 24'hFFFFFF);

        // Asynchronous reset at word 8, then full replay.
        start(2, 20);
        n = 0;
        for (int c = 0; c < 100; c++) begin
            if (o_valid) begin
                if (n == 8) break;
                n++;
            end
            tick();
        end
        check("reached w8", 32'(n), 32'd8);
        #2 i_rst_n = 1'b0;
        #1;
        check("arst valid", 32'(o_valid), 32'd0);
        check("arst busy",  32'(o_busy),  32'd0);
        check("arst data",  32'(o_data),  32'd0);
        tick();
        check("arst valid hold", 32'(o_valid), 32'd0);
        i_rst_n = 1'b1;
        fill(c_RED);
        exp_w[0] = 24'h0000AA;
        exp_w[3] = 24'h0F0000;
        start(2, 20);
        collect("replay");

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog");
    end

endmodule

`default_nettype wire
